plot_motion_ctrl: RTL

Motion sequencer for the pen-plotter datapath. Accepts one move command at a time over a valid/ready handshake and raises or lowers the pen with a settle delay. It then drives the X/Y stepper step/direction lines along a Bresenham straight line to the target, tracking absolute position. It sits between the processor's motion registers and the stepper/servo drivers, replacing free-running speed/direction control.

---
 rtl/plot_pkg.sv | 17 +
 rtl/step_rate_div.sv | 40 ++++
 rtl/plot_motion_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/plot_pkg.sv
// Shared encodings for the pen-plotter motion sequencer: FSM states and the
// logic levels used on the direction and pen servo lines.
package plot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEN  = 2'd1,
    MOVE = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic DIR_POS  = 1'b1;
  localparam logic DIR_NEG  = 1'b0;
  localparam logic PEN_DOWN = 1'b1;
  localparam logic PEN_UP   = 1'b0;

endpackage

// File: rtl/step_rate_div.sv
// Motion tick generator: counts 0..STEP_DIV-1 while enabled and flags the
// wrapping cycle. A synchronous clear restarts the count from zero.
module step_rate_div #(
  parameter int STEP_DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && !clear && (cnt_q == CNT_LAST);

  // Next count: clear has priority, then wrap on the tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/plot_motion_ctrl.sv
// Pen-plotter motion sequencer: accepts one move/home command, sets the pen
// level with a settle delay, then walks a Bresenham line to the target while
// emitting step/dir pulses and tracking the absolute position.
module plot_motion_ctrl
  import plot_pkg::*;
#(
  parameter int STEP_DIV   = 100000,
  parameter int PEN_SETTLE = 25000000,
  parameter int POS_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_x,
  input  logic [POS_W-1:0] cmd_y,
  input  logic             cmd_pen,
  input  logic             cmd_home,
  input  logic             abort,
  output logic             step_x,
  output logic             step_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             pen_down,
  output logic [POS_W-1:0] cur_x,
  output logic [POS_W-1:0] cur_y,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(PEN_SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(PEN_SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic signed [POS_W+1:0] ERR_ZERO = '0;

  // Position step by one in the latched direction; wraps at POS_W.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                input logic dir);
    return (dir == DIR_POS) ? p + POS_ONE : p - POS_ONE;
  endfunction

  // Magnitude of a sign-extended difference; never overflows POS_W+1 bits.
  function automatic logic [POS_W:0] abs_diff(input logic signed [POS_W:0] d);
    return d[POS_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  state_e state_q, state_d;
  logic [POS_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [POS_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [POS_W:0]   dx_q, dx_d, dy_q, dy_d;
  logic signed [POS_W+1:0] err_q, err_d;
  logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic pen_q, pen_d;
  logic step_x_q, step_x_d, step_y_q, step_y_d;
  logic done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic [SW-1:0] settle_q, settle_d;
  logic div_clear, tick;

  logic signed [POS_W:0]   diff_x, diff_y;
  logic [POS_W:0]          dx_load, dy_load;
  logic signed [POS_W+1:0] err_load, dx_e, dy_e, err_step;
  logic signed [POS_W+2:0] e2, dx_e2, dy_e2;
  logic go_x, go_y, at_target;

  step_rate_div #(.STEP_DIV(STEP_DIV)) u_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (div_clear),
    .enable (state_q == MOVE),
    .tick   (tick)
  );

  // Command geometry relative to the current position.
  assign diff_x   = $signed({cmd_x[POS_W-1], cmd_x}) - $signed({cur_x_q[POS_W-1], cur_x_q});
  assign diff_y   = $signed({cmd_y[POS_W-1], cmd_y}) - $signed({cur_y_q[POS_W-1], cur_y_q});
  assign dx_load  = abs_diff(diff_x);
  assign dy_load  = abs_diff(diff_y);
  assign err_load = $signed({1'b0, dx_load}) - $signed({1'b0, dy_load});

  // Bresenham decision on the latched error term.
  assign dx_e      = $signed({1'b0, dx_q});
  assign dy_e      = $signed({1'b0, dy_q});
  assign e2        = $signed({err_q, 1'b0});
  assign dx_e2     = $signed({2'b00, dx_q});
  assign dy_e2     = $signed({2'b00, dy_q});
  assign go_x      = e2 > -dy_e2;
  assign go_y      = e2 < dx_e2;
  assign err_step  = err_q - (go_x ? dy_e : ERR_ZERO) + (go_y ? dx_e : ERR_ZERO);
  assign at_target = (cur_x_q == tgt_x_q) && (cur_y_q == tgt_y_q);

  // Sequencer next-state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    err_d     = err_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    pen_d     = pen_q;
    settle_d  = settle_q;
    step_x_d  = 1'b0;
    step_y_d  = 1'b0;
    done_d    = 1'b0;
    div_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          if (cmd_home) begin
            cur_x_d = '0;
            cur_y_d = '0;
            state_d = DONE;
          end else begin
            tgt_x_d = cmd_x;
            tgt_y_d = cmd_y;
            dir_x_d = diff_x[POS_W] ? DIR_NEG : DIR_POS;
            dir_y_d = diff_y[POS_W] ? DIR_NEG : DIR_POS;
            dx_d    = dx_load;
            dy_d    = dy_load;
            err_d   = err_load;
            if (cmd_pen != pen_q) begin
              pen_d    = cmd_pen;
              settle_d = '0;
              state_d  = PEN;
            end else begin
              state_d   = MOVE;
              div_clear = 1'b1;
            end
          end
        end
      end
      PEN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d   = MOVE;
          div_clear = 1'b1;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      MOVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (at_target) begin
          state_d = DONE;
        end else if (tick) begin
          if (go_x) begin
            cur_x_d  = step_pos(cur_x_q, dir_x_q);
            step_x_d = 1'b1;
          end
          if (go_y) begin
            cur_y_d  = step_pos(cur_y_q, dir_y_q);
            step_y_d = 1'b1;
          end
          err_d = err_step;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = !abort;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready stays low through the cycle that shows the done pulse.
  assign ready_d = (state_d == IDLE) && !((state_q == DONE) && !abort);
  assign busy_d  = (state_d != IDLE);

  // Control, position and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dir_x_q  <= DIR_NEG;
      dir_y_q  <= DIR_NEG;
      pen_q    <= PEN_UP;
      settle_q <= '0;
      step_x_q <= 1'b0;
      step_y_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      pen_q    <= pen_d;
      settle_q <= settle_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Latched command geometry; always loaded before it is used.
  always_ff @(posedge clock) begin
    tgt_x_q <= tgt_x_d;
    tgt_y_q <= tgt_y_d;
    dx_q    <= dx_d;
    dy_q    <= dy_d;
    err_q   <= err_d;
  end

  assign cmd_ready = ready_q;
  assign step_x    = step_x_q;
  assign step_y    = step_y_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign pen_down  = pen_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
